m3_clk_freq_meter: RTL
======================

# m3_clk_freq_meter

Measures the core clock frequency in Hz against a slow, free-running reference oscillator. It produces the 32-bit value that the SOPC core-clock-frequency PIO input port exposes to software. The block sits in the core clock domain, beside the Qsys system, and drives that PIO's `in_port` directly.

## Interface
- `REF_HZ`, 1_000_000: nominal frequency of `ref_clk` in Hz.
- `GATE_EDGES`, 1_000_000: `ref_clk` rising edges per measurement window. `REF_HZ` must be an integer multiple of `GATE_EDGES`; the derived constant is `SCALE = REF_HZ / GATE_EDGES`.
- `TIMEOUT_CYCLES`, 2_000_000: number of `clk` cycles without a reference edge before the reference is declared lost.
- `clk` in 1: core clock, which is also the clock being measured.
- `reset_n` in 1: asynchronous, active-low reset.
- `ref_clk` in 1: reference oscillator, asynchronous to `clk`.
- `freq_hz` out 32: last measured frequency in Hz; this connects to the PIO `in_port`.
- `freq_valid` out 1: `freq_hz` holds a valid measurement.
- `freq_upd` out 1: one-cycle pulse, asserted in the cycle `freq_hz` changes.
- `ref_lost` out 1: reference timeout flag.
- `cnt_ovf` out 1: the last window's count saturated.

## Operation
- **Synchronizer:** `ref_clk` passes through a 2-flop synchronizer and then an edge register. `ref_edge` is a one-cycle pulse on each synchronized rising edge.
- **States:**
  - WAIT_SYNC (reset state): waits for `ref_edge`.
  - COUNT: counts `clk` cycles and reference edges within the window.
- **WAIT_SYNC → COUNT** on `ref_edge`. On this transition, `clk_cnt := 1` and `edge_cnt := 0`.
- **In COUNT, each cycle:**
  - `clk_cnt` increments, saturating at 2^32−1.
  - On `ref_edge`, `edge_cnt` increments.
- **Window end:** when `ref_edge` arrives with `edge_cnt == GATE_EDGES−1`:
  - Latch `result = min(clk_cnt × SCALE, 2^32−1)`. The product is computed at 64 bits; any bits above 32 force saturation.
  - Set `cnt_ovf` = 1 if `clk_cnt` was saturated or the product exceeded 32 bits, else 0.
  - Restart the window back-to-back: `clk_cnt := 1`, `edge_cnt := 0`. The terminal edge is the first edge of the next window, so no reference edges are lost.
- **Timeout:**
  - `idle_cnt` resets on every `ref_edge` and increments otherwise.
  - When `idle_cnt` reaches `TIMEOUT_CYCLES`: set `ref_lost` = 1, clear `freq_valid`, force `freq_hz` = 0, and go to WAIT_SYNC.
  - `ref_lost` clears on the next `ref_edge`. A partial window is discarded and never reported.
- **Simultaneous timeout and `ref_edge`:** the edge wins, and no timeout is taken.
- **Reset mid-window:** all state clears immediately and asynchronously. The first result after reset needs a full window starting at the first edge.

## Timing
- **Reset values:** `freq_hz` = 0, `freq_valid` = 0, `freq_upd` = 0, `ref_lost` = 0, `cnt_ovf` = 0. State is WAIT_SYNC and all counters are 0.
- **`ref_clk` rising edge to `ref_edge`:** 2–3 `clk` cycles of synchronizer latency.
- **Output update:** `freq_hz`, `freq_valid` (set to 1), `cnt_ovf` and `freq_upd` all update on the clock edge after the terminal `ref_edge` cycle, i.e. registered with 1-cycle latency.
- **`freq_hz` hold:** the value is stable between updates, so the PIO may sample it in any cycle.
- **Measurement error:** ±1 count per window (synchronizer quantization) × `SCALE` Hz.

## Configuration
- **`M3_FREQ_METER_AVG_EN` defined:**
  - `freq_hz` is the mean of the last 4 window results: `(r0+r1+r2+r3) >> 2`, with a 34-bit sum.
  - `freq_valid` rises only after 4 consecutive windows following reset or `ref_lost`.
  - The history clears on reset and on timeout.
- **Undefined:** `freq_hz` is the raw result of the latest window, and `freq_valid` rises after the first window.

## Structure
- **Package `m3_freq_meter_pkg`:** the state enum (WAIT_SYNC, COUNT), `CNT_W` = 32, `PROD_W` = 64, and the `AVG_DEPTH` = 4 constant.
- **Sub-module `m3_sync2`:** the 2-flop synchronizer with asynchronous active-low reset, reusable for other asynchronous inputs.
- **Top level:** the FSM, counters, scaler and optional averager live in `m3_clk_freq_meter`.

## Test plan
All scenarios use `REF_HZ` = 1000, `GATE_EDGES` = 10 (`SCALE` = 100) and `TIMEOUT_CYCLES` = 200, with `ref_clk` period = 50 `clk` periods unless stated otherwise.
- **Steady state:** after the first edge plus 10 edges, `freq_hz` = 50000, `freq_valid` = 1, and `freq_upd` pulses once. Subsequent windows also give 50000.
- **Frequency step:** change the `ref_clk` period to 40 `clk` periods mid-run. Expect one transitional window, then `freq_hz` = 40000. With `M3_FREQ_METER_AVG_EN`, 40000 appears after 4 full windows.
- **Reference stops:** stop `ref_clk` for more than 200 cycles. Expect `ref_lost` = 1, `freq_hz` = 0 and `freq_valid` = 0. On resume, `ref_lost` = 0 at the first edge, and `freq_hz` = 50000 after the next full window.
- **Overflow:** `SCALE` = 2^28 with a 50-cycle reference period (product 10×50×2^28 > 2^32). Expect `freq_hz` = 0xFFFF_FFFF and `cnt_ovf` = 1.
- **Reset mid-window:** assert `reset_n` during the 5th edge of a window. All outputs read 0 immediately. After release, the first `freq_upd` comes 11 edges later with `freq_hz` = 50000.
- **Edge/timeout collision:** a `ref_edge` arriving in the same cycle `idle_cnt` reaches 200 leaves `ref_lost` = 0, and the window continues.

Source files
------------

// File: rtl/m3_freq_meter_pkg.sv
// Shared types and constants for the core clock frequency meter.
package m3_freq_meter_pkg;

  typedef enum logic {
    WAIT_SYNC,
    COUNT
  } state_e;

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned AVG_DEPTH = 4;

endpackage

// File: rtl/m3_sync2.sv
// Two-flop synchronizer for a single asynchronous input; asynchronous active-low reset.
module m3_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/m3_clk_freq_meter.sv
// Measures clk frequency in Hz by counting clk cycles over GATE_EDGES reference edges.
// Define M3_FREQ_METER_AVG_EN to report the mean of the last AVG_DEPTH window results.
module m3_clk_freq_meter
  import m3_freq_meter_pkg::*;
#(
  parameter int unsigned REF_HZ         = 1_000_000,
  parameter int unsigned GATE_EDGES     = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ref_clk,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        freq_upd,
  output logic        ref_lost,
  output logic        cnt_ovf
);

  localparam logic [CNT_W-1:0] SCALE     = CNT_W'(REF_HZ / GATE_EDGES);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(GATE_EDGES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic              ref_sync, ref_prev_q, ref_prev_d, ref_edge;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  freq_hz_q, freq_hz_d;
  logic              freq_valid_q, freq_valid_d;
  logic              freq_upd_q, freq_upd_d;
  logic              ref_lost_q, ref_lost_d;
  logic              cnt_ovf_q, cnt_ovf_d;
  logic              start, win_end, timeout;
  logic [PROD_W-1:0] prod;
  logic              prod_sat;
  logic [CNT_W-1:0]  result, out_hz;
  logic              out_valid;

  m3_sync2 u_ref_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ref_clk),
    .q       (ref_sync)
  );

  assign ref_prev_d = ref_sync;
  assign ref_edge   = ref_sync & ~ref_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (ref_edge) state_d = COUNT;
      COUNT:     if (timeout)  state_d = WAIT_SYNC;
      default:   state_d = WAIT_SYNC;
    endcase
  end

  // A reference edge in the timeout cycle wins, so timeout never coincides with ref_edge.
  always_comb begin
    timeout = (idle_cnt_q >= TIMEOUT) && !ref_edge;
    start   = (state_q == WAIT_SYNC) && ref_edge;
    win_end = (state_q == COUNT) && ref_edge && (edge_cnt_q == LAST_EDGE);
  end

  always_comb begin
    clk_cnt_d  = clk_cnt_q;
    edge_cnt_d = edge_cnt_q;
    idle_cnt_d = ref_edge ? '0 : ((idle_cnt_q >= TIMEOUT) ? idle_cnt_q : idle_cnt_q + 1'b1);
    if (timeout) begin
      clk_cnt_d  = '0;
      edge_cnt_d = '0;
    end else if (start || win_end) begin
      clk_cnt_d  = CNT_W'(1);
      edge_cnt_d = '0;
    end else if (state_q == COUNT) begin
      if (clk_cnt_q != '1) clk_cnt_d = clk_cnt_q + 1'b1;
      if (ref_edge)        edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_comb begin
    prod     = PROD_W'(clk_cnt_q) * PROD_W'(SCALE);
    prod_sat = (clk_cnt_q == '1) || (prod[PROD_W-1:CNT_W] != '0);
    result   = prod_sat ? '1 : prod[CNT_W-1:0];
  end

`ifdef M3_FREQ_METER_AVG_EN
  localparam int unsigned HCNT_W = $clog2(AVG_DEPTH + 1);

  logic [CNT_W-1:0]  hist_q [AVG_DEPTH];
  logic [CNT_W-1:0]  hist_d [AVG_DEPTH];
  logic [HCNT_W-1:0] hist_cnt_q, hist_cnt_d;
  logic [CNT_W+1:0]  hist_sum;

  // The mean is taken over the history as it will be after this cycle's update.
  always_comb begin
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    if (timeout) begin
      hist_d     = '{default: '0};
      hist_cnt_d = '0;
    end else if (win_end) begin
      hist_d[0] = result;
      for (int unsigned i = 1; i < AVG_DEPTH; i++) hist_d[i] = hist_q[i-1];
      if (hist_cnt_q != HCNT_W'(AVG_DEPTH)) hist_cnt_d = hist_cnt_q + 1'b1;
    end
    hist_sum = '0;
    for (int unsigned i = 0; i < AVG_DEPTH; i++) hist_sum = hist_sum + (CNT_W+2)'(hist_d[i]);
    out_hz    = hist_sum[CNT_W+1:2];
    out_valid = (hist_cnt_d == HCNT_W'(AVG_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q     <= '{default: '0};
      hist_cnt_q <= '0;
    end else begin
      hist_q     <= hist_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end
`else
  always_comb begin
    out_hz    = result;
    out_valid = 1'b1;
  end
`endif

  always_comb begin
    freq_hz_d    = freq_hz_q;
    freq_valid_d = freq_valid_q;
    cnt_ovf_d    = cnt_ovf_q;
    freq_upd_d   = win_end;
    ref_lost_d   = ref_edge ? 1'b0 : (timeout ? 1'b1 : ref_lost_q);
    if (timeout) begin
      freq_hz_d    = '0;
      freq_valid_d = 1'b0;
    end else if (win_end) begin
      freq_hz_d    = out_hz;
      freq_valid_d = out_valid;
      cnt_ovf_d    = prod_sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_prev_q   <= 1'b0;
      clk_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      freq_hz_q    <= '0;
      freq_valid_q <= 1'b0;
      freq_upd_q   <= 1'b0;
      ref_lost_q   <= 1'b0;
      cnt_ovf_q    <= 1'b0;
    end else begin
      ref_prev_q   <= ref_prev_d;
      clk_cnt_q    <= clk_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      freq_hz_q    <= freq_hz_d;
      freq_valid_q <= freq_valid_d;
      freq_upd_q   <= freq_upd_d;
      ref_lost_q   <= ref_lost_d;
      cnt_ovf_q    <= cnt_ovf_d;
    end
  end

  assign freq_hz    = freq_hz_q;
  assign freq_valid = freq_valid_q;
  assign freq_upd   = freq_upd_q;
  assign ref_lost   = ref_lost_q;
  assign cnt_ovf    = cnt_ovf_q;

endmodule
